// File: rtl/uart_io_queue_if.sv
// rtl/uart_io_queue_if.sv - send/recv request handshakes between the core and the UART queue
interface send_request_if;
    logic        en;
    logic [31:0] data;
    logic        busy;

    modport master (output en, data, input busy);
    modport slave  (input en, data, output busy);
endinterface

interface recv_request_if;
    logic        en;
    logic [31:0] rd;
    logic [7:0]  size;

    modport master (output en, input rd, size);
    modport slave  (input en, output rd, size);
endinterface

// File: rtl/uart_io_queue.sv
// rtl/uart_io_queue.sv - word-level 8N1 UART endpoint with TX and RX word FIFOs
module uart_io_queue #(
    parameter int CLK_PER_BIT = 868,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    send_request_if.slave  io_send,
    recv_request_if.slave  io_recv,
    output logic           txd,
    input  logic           rxd,
    output logic           rx_overrun
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int TW  = $clog2(CLK_PER_BIT);

    localparam logic [TW-1:0]  BIT_LAST     = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0]  BIT_HALF     = TW'(CLK_PER_BIT / 2);
    localparam logic [TCW-1:0] TX_FULL_MARK = TCW'(TX_DEPTH - 1);
    localparam logic [RCW-1:0] RX_FULL      = RCW'(RX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // ---------------- TX ----------------
    logic [31:0]    tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TCW-1:0] tx_count, tx_count_n;
    logic           tx_push, tx_pop, tx_busy, tx_tick;
    uart_state_t    tx_state, tx_state_n;
    logic [TW-1:0]  tx_timer;
    logic [31:0]    tx_shift;
    logic [1:0]     tx_byte_idx;
    logic [2:0]     tx_bit_idx;

    assign tx_push      = io_send.en & ~tx_busy;
    assign tx_count_n   = tx_count + TCW'(tx_push) - TCW'(tx_pop);
    assign tx_tick      = (tx_timer == BIT_LAST);
    assign io_send.busy = tx_busy;

    // After the last stop bit a waiting word is popped directly so words run back to back.
    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (tx_count != '0) begin
                    tx_pop     = 1'b1;
                    tx_state_n = S_START;
                end
            end
            S_START: if (tx_tick) tx_state_n = S_DATA;
            S_DATA:  if (tx_tick && tx_bit_idx == 3'd7) tx_state_n = S_STOP;
            S_STOP: begin
                if (tx_tick) begin
                    if (tx_byte_idx != 2'd3) begin
                        tx_state_n = S_START;
                    end else if (tx_count != '0) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tx_state <= S_IDLE;
        else          tx_state <= tx_state_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            tx_count    <= '0;
            tx_busy     <= 1'b0;
            tx_timer    <= '0;
            tx_shift    <= '0;
            tx_byte_idx <= '0;
            tx_bit_idx  <= '0;
            txd         <= 1'b1;
        end else begin
            tx_count <= tx_count_n;
            tx_busy  <= (tx_count_n >= TX_FULL_MARK);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_state_n != tx_state || tx_tick || tx_state == S_IDLE) tx_timer <= '0;
            else                                                          tx_timer <= tx_timer + 1'b1;
            if (tx_pop) begin
                tx_shift    <= tx_mem[tx_rd_ptr];
                tx_byte_idx <= '0;
                tx_bit_idx  <= '0;
            end else if (tx_state == S_DATA && tx_tick) begin
                tx_bit_idx <= tx_bit_idx + 1'b1;
            end else if (tx_state == S_STOP && tx_tick) begin
                tx_shift    <= {8'h00, tx_shift[31:8]};
                tx_byte_idx <= tx_byte_idx + 1'b1;
            end
            // Registered line: the first start bit appears one cycle after the FIFO pop.
            case (tx_state)
                S_START: txd <= 1'b0;
                S_DATA:  txd <= tx_shift[tx_bit_idx];
                default: txd <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= io_send.data;
    end

    // ---------------- RX ----------------
    logic [31:0]    rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RCW-1:0] rx_count;
    logic [1:0]     rx_sync;
    logic           rx_s, rx_prev, rx_mid, rx_tick;
    uart_state_t    rx_state, rx_state_n;
    logic [TW-1:0]  rx_timer;
    logic [2:0]     rx_bit_idx;
    logic [7:0]     rx_shift;
    logic [1:0]     rx_byte_idx;
    logic [23:0]    rx_word;
    logic           rx_byte_ok, rx_word_done, rx_full, rx_push, rx_pop;

    assign rx_s         = rx_sync[1];
    assign rx_mid       = (rx_timer == BIT_HALF);
    assign rx_tick      = (rx_timer == BIT_LAST);
    assign rx_word_done = rx_byte_ok && (rx_byte_idx == 2'd3);
    assign rx_full      = (rx_count == RX_FULL);
    assign rx_push      = rx_word_done & ~rx_full;
    assign rx_pop       = io_recv.en & (rx_count != '0);
    assign io_recv.size = 8'(rx_count);
    assign io_recv.rd   = (rx_count != '0) ? rx_mem[rx_rd_ptr] : 32'h0;

    always_comb begin
        rx_state_n = rx_state;
        rx_byte_ok = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s) rx_state_n = S_START;
            S_START: if (rx_mid) rx_state_n = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit_idx == 3'd7) rx_state_n = S_STOP;
            S_STOP: begin
                if (rx_tick) begin
                    rx_state_n = S_IDLE;
                    rx_byte_ok = rx_s;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rx_state <= S_IDLE;
        else          rx_state <= rx_state_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync     <= 2'b11;
            rx_prev     <= 1'b1;
            rx_timer    <= '0;
            rx_bit_idx  <= '0;
            rx_shift    <= '0;
            rx_byte_idx <= '0;
            rx_word     <= '0;
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= '0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_prev <= rx_s;
            if (rx_state_n != rx_state || rx_tick || rx_state == S_IDLE) rx_timer <= '0;
            else                                                          rx_timer <= rx_timer + 1'b1;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift   <= {rx_s, rx_shift[7:1]};
                rx_bit_idx <= rx_bit_idx + 1'b1;
            end
            // Framing errors never reach here, so a bad byte leaves the assembler untouched.
            if (rx_byte_ok) begin
                rx_byte_idx <= rx_byte_idx + 1'b1;
                case (rx_byte_idx)
                    2'd0:    rx_word[7:0]   <= rx_shift;
                    2'd1:    rx_word[15:8]  <= rx_shift;
                    2'd2:    rx_word[23:16] <= rx_shift;
                    default: ;
                endcase
            end
            if (rx_word_done && rx_full) rx_overrun <= 1'b1;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + RCW'(rx_push) - RCW'(rx_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= {rx_shift, rx_word};
    end
endmodule

// File: tb/tb_uart_io_queue.sv
// tb/tb_uart_io_queue.sv - scoreboard bench for uart_io_queue
module tb_uart_io_queue;
    localparam int CPB = 4;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic rxd, txd, rx_overrun;

    always #5 clock = ~clock;

    send_request_if io_send();
    recv_request_if io_recv();

    assign rxd = loop_en ? txd : rxd_drv;

    uart_io_queue #(.CLK_PER_BIT(CPB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .io_send    (io_send),
        .io_recv    (io_recv),
        .txd        (txd),
        .rxd        (rxd),
        .rx_overrun (rx_overrun)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit mon_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Decodes txd frames into words and compares them against the TX scoreboard.
    initial begin : tx_monitor
        logic [31:0] w;
        logic [31:0] exp;
        logic [7:0]  b;
        logic        prev;
        int          nb;
        w = '0; b = '0; prev = 1'b1; nb = 0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                nb = 0;
            end else if (prev && !txd) begin
                repeat (2) @(negedge clock);
                if (mon_en) check("tx_start", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clock);
                if (mon_en) check("tx_stop", 32'(txd), 32'd1);
                w[8*nb +: 8] = b;
                nb++;
                if (nb == 4) begin
                    nb = 0;
                    if (mon_en) begin
                        exp = (tx_q.size() != 0) ? tx_q.pop_front() : ~w;
                        check("tx_word", w, exp);
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic push_tx(input logic [31:0] w, input bit track);
        @(negedge clock);
        io_send.en = 1'b1;
        io_send.data = w;
        if (track) tx_q.push_back(w);
        @(negedge clock);
        io_send.en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rxd_drv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            rxd_drv = b[i];
        end
        repeat (CPB) @(negedge clock);
        rxd_drv = stop;
        repeat (CPB) @(negedge clock);
        rxd_drv = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic pop_rx();
        logic [31:0] exp;
        @(negedge clock);
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
        check("rx_rd", io_recv.rd, exp);
        io_recv.en = 1'b1;
        @(negedge clock);
        io_recv.en = 1'b0;
    endtask

    task automatic wait_size(input int n, input int budget);
        int c = 0;
        while (int'(io_recv.size) != n && c < budget) begin
            @(negedge clock);
            c++;
        end
        check("size_wait", 32'(io_recv.size), 32'(n));
    endtask

    task automatic wait_tx_drain(input int budget);
        int c = 0;
        while (tx_q.size() != 0 && c < budget) begin
            @(negedge clock);
            c++;
        end
        check("tx_drain", 32'(tx_q.size()), 32'd0);
        repeat (10) @(negedge clock);
    endtask

    initial begin : stimulus
        logic [31:0] w;
        logic [31:0] d;
        io_send.en = 1'b0;
        io_send.data = '0;
        io_recv.en = 1'b0;

        // Reset values, held and after release.
        repeat (5) @(negedge clock);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(io_send.busy), 32'd0);
        check("rst_size", 32'(io_recv.size), 32'd0);
        check("rst_rd", io_recv.rd, 32'd0);
        check("rst_ovr", 32'(rx_overrun), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_flags", {29'd0, txd, io_send.busy, rx_overrun}, 32'h4);
            check("idle_recv", io_recv.rd | 32'(io_recv.size), 32'd0);
        end

        // TX framing and first-start latency.
        @(negedge clock);
        io_send.en = 1'b1;
        io_send.data = 32'h4433_2211;
        tx_q.push_back(32'h4433_2211);
        @(negedge clock);
        io_send.en = 1'b0;
        check("tx_lat0", 32'(txd), 32'd1);
        @(negedge clock);
        check("tx_lat1", 32'(txd), 32'd1);
        @(negedge clock);
        check("tx_lat2", 32'(txd), 32'd0);
        wait_tx_drain(300);

        // TX backpressure: one word leaves immediately, then TX_DEPTH-1 fit before busy.
        for (int i = 0; i < TXD + 2; i++) begin
            @(negedge clock);
            check("tx_busy", 32'(io_send.busy), 32'(i >= TXD));
            w = $urandom();
            io_send.en = 1'b1;
            io_send.data = w;
            if (i < TXD) tx_q.push_back(w);
        end
        @(negedge clock);
        io_send.en = 1'b0;
        wait_tx_drain(3000);
        check("tx_busy_clear", 32'(io_send.busy), 32'd0);

        // Loopback.
        loop_en = 1'b1;
        push_tx(32'hDEAD_BEEF, 1'b1);
        rx_q.push_back(32'hDEAD_BEEF);
        push_tx(32'h0000_0001, 1'b1);
        rx_q.push_back(32'h0000_0001);
        wait_size(1, 400);
        check("lb_head", io_recv.rd, rx_q[0]);
        wait_size(2, 400);
        pop_rx();
        check("lb_next", io_recv.rd, rx_q[0]);
        check("lb_size1", 32'(io_recv.size), 32'd1);
        pop_rx();
        check("lb_size0", 32'(io_recv.size), 32'd0);
        check("lb_rd_empty", io_recv.rd, 32'd0);
        wait_tx_drain(400);
        loop_en = 1'b0;
        repeat (10) @(negedge clock);

        // Glitch and framing error leave the word assembler aligned.
        @(negedge clock);
        rxd_drv = 1'b0;
        @(negedge clock);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clock);
        check("glitch_size", 32'(io_recv.size), 32'd0);
        send_byte(8'hAA, 1'b0);
        rx_q.push_back(32'h1234_5678);
        send_word(32'h1234_5678);
        wait_size(1, 50);
        pop_rx();
        check("frame_size0", 32'(io_recv.size), 32'd0);

        // Fill RX, then overrun.
        for (int i = 0; i < RXD; i++) begin
            w = $urandom();
            rx_q.push_back(w);
            send_word(w);
        end
        wait_size(RXD, 50);
        check("ovr_pre", 32'(rx_overrun), 32'd0);
        send_word(32'h0BAD_0BAD);
        repeat (10) @(negedge clock);
        check("ovr_size", 32'(io_recv.size), 32'(RXD));
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        for (int i = 0; i < RXD; i++) pop_rx();
        check("ovr_drained", 32'(io_recv.size), 32'd0);
        check("ovr_sticky", 32'(rx_overrun), 32'd1);

        // Pop lands on the same edge as the fourth byte's push.
        for (int i = 0; i < 3; i++) begin
            w = 32'hA000_0000 | 32'(i);
            rx_q.push_back(w);
            send_word(w);
        end
        wait_size(3, 50);
        d = 32'hCAFE_F00D;
        rx_q.push_back(d);
        for (int k = 0; k < 3; k++) send_byte(d[8*k +: 8], 1'b1);
        check("simul_head", io_recv.rd, rx_q[0]);
        fork
            send_byte(d[31:24], 1'b1);
            begin
                repeat (42) @(negedge clock);
                io_recv.en = 1'b1;
                @(negedge clock);
                io_recv.en = 1'b0;
            end
        join
        void'(rx_q.pop_front());
        check("simul_size", 32'(io_recv.size), 32'd3);
        check("simul_next", io_recv.rd, rx_q[0]);
        pop_rx();
        pop_rx();
        check("simul_tail", io_recv.rd, rx_q[0]);
        check("simul_size1", 32'(io_recv.size), 32'd1);

        // Reset in the middle of a transmitted byte.
        mon_en = 1'b0;
        push_tx(32'h0000_0000, 1'b0);
        repeat (28) @(negedge clock);
        check("pre_rst_txd", 32'(txd), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_size", 32'(io_recv.size), 32'd0);
        check("mid_rst_rd", io_recv.rd, 32'd0);
        check("mid_rst_busy", 32'(io_send.busy), 32'd0);
        check("mid_rst_ovr", 32'(rx_overrun), 32'd0);
        rx_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check("post_rst_txd", 32'(txd), 32'd1);
        check("post_rst_size", 32'(io_recv.size), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
